// File: rtl/wb_uart_tx.sv
// wb_uart_tx -- Wishbone slave UART transmitter (8N1, programmable bit period).
//
// The CPU pushes bytes into a TX FIFO through the DATA register. A serializer
// pops them and shifts them out LSB first as 8N1 frames. Each bit lasts BAUD+1
// clocks.
//
// Register map (adr_i[1:0]):
//   0 DATA   W: push one byte (lane picked by sel_i); R: 0
//   1 STATUS R: [0] full [1] empty [2] busy [3] overflow [8] irq enable
//               [15:11] FIFO count (saturated to 31)
//            W: dat_i[3]=1 clears overflow; dat_i[8] writes irq enable
//   2 BAUD   R/W: bit period minus one, byte-lane writes via sel_i
//   3 reserved: reads 0, writes ignored
//
// Ports:
//   clk_i         single clock, rising edge
//   rst_i         synchronous active-high reset
//   cyc_i, stb_i  Wishbone cycle / strobe
//   we_i          1 = write, 0 = read
//   sel_i[1:0]    byte lane select
//   adr_i[14:0]   word address, only [1:0] decoded
//   dat_i[15:0]   write data
//   ack_o         registered acknowledge (one wait state)
//   dat_o[15:0]   read data, valid while ack_o=1, 0 otherwise
//   tx_o          serial output, idle high, registered
//   irq_o         (only with WB_UART_TX_IRQ_EN) ie & FIFO empty & serializer idle
//
// Optional feature macro: WB_UART_TX_IRQ_EN (adds irq_o and the STATUS[8]
// interrupt-enable bit; without it STATUS[8] reads 0 and ignores writes).

module wb_uart_tx #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [1:0]  sel_i,
  input  logic [14:0] adr_i,
  input  logic [15:0] dat_i,
  output logic        ack_o,
  output logic [15:0] dat_o,
  output logic        tx_o
`ifdef WB_UART_TX_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Bus decode
  logic        bus_req, wr_req, rd_req;
  logic [1:0]  reg_sel;
  logic [15:0] rdata;

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [4:0]    count_sat;
  logic          full, empty, push_req, push, pop, drop;
  logic [7:0]    push_byte;

  // Registers
  logic [15:0] baud;
  logic        overflow;
  logic        ie;

  // Serializer
  state_t      state;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic [15:0] reload, tick;
  logic        busy;

  // Only the low two address bits select a register.
  logic unused_adr;
  assign unused_adr = ^adr_i[14:2];

  // A new request is one that is not already being acknowledged this cycle,
  // which is what gives a held strobe ack pulses on alternating cycles.
  assign bus_req = cyc_i & stb_i & ~ack_o;
  assign wr_req  = bus_req & we_i;
  assign rd_req  = bus_req & ~we_i;
  assign reg_sel = adr_i[1:0];

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign busy  = (state != S_IDLE);

  assign push_byte = (sel_i == 2'b10) ? dat_i[15:8] : dat_i[7:0];
  assign push_req  = wr_req && (reg_sel == 2'd0) && (sel_i != 2'b00);
  assign pop       = (state == S_IDLE) && !empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  assign count_sat = (int'(count) > 31) ? 5'd31 : 5'(count);

  // NOTE: every variable assigned in always_comb gets a default first so no
  // latch is inferred on paths that do not assign it.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd1:    rdata = {count_sat, 2'b00, ie, 4'b0000, overflow, busy, empty, full};
      2'd2:    rdata = baud;
      default: rdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= cyc_i & stb_i & ~ack_o;
      dat_o <= rd_req ? rdata : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud     <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (wr_req && reg_sel == 2'd2) begin
        if (sel_i[0]) baud[7:0]  <= dat_i[7:0];
        if (sel_i[1]) baud[15:8] <= dat_i[15:8];
      end
      if (drop)
        overflow <= 1'b1;
      else if (wr_req && reg_sel == 2'd1 && dat_i[3])
        overflow <= 1'b0;
    end
  end

`ifdef WB_UART_TX_IRQ_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ie    <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (wr_req && reg_sel == 2'd1) ie <= dat_i[8];
      irq_o <= ie & empty & ~busy;
    end
  end
`else
  assign ie = 1'b0;
`endif

  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers and count, so stale entries are never observed.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serializer: tick counts reload..0, so each bit lasts reload+1 clocks.
  // reload is captured at pop time, so BAUD writes mid-frame wait for the
  // next frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      tx_o    <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
      reload  <= '0;
      tick    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx_o <= 1'b1;
          if (!empty) begin
            shreg  <= mem[rd_ptr];
            reload <= baud;
            tick   <= baud;
            tx_o   <= 1'b0;
            state  <= S_START;
          end
        end
        S_START: begin
          if (tick == '0) begin
            tick    <= reload;
            tx_o    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            tick <= tick - 1'b1;
          end
        end
        S_DATA: begin
          if (tick == '0) begin
            tick <= reload;
            if (bit_idx == 3'd7) begin
              tx_o  <= 1'b1;
              state <= S_STOP;
            end else begin
              tx_o    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            tick <= tick - 1'b1;
          end
        end
        S_STOP: begin
          if (tick == '0) state <= S_IDLE;
          else            tick  <= tick - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
